// File: rtl/poly_mul_pkg.sv
// Shared codes for the polynomial-multiply sequencer and the core side.
// Holds conf/mode codes, FSM encoding, timing defaults and phase tables.
package poly_mul_pkg;

   localparam logic [2:0] CONF_HOLD  = 3'd0;
   localparam logic [2:0] CONF_NTT_A = 3'd1;
   localparam logic [2:0] CONF_NTT_B = 3'd2;
   localparam logic [2:0] CONF_PWM   = 3'd3;
   localparam logic [2:0] CONF_INTT  = 3'd4;

   localparam logic [1:0] MODE_NTT  = 2'd0;
   localparam logic [1:0] MODE_INTT = 2'd1;
   localparam logic [1:0] MODE_MUL  = 2'd2;
   localparam logic [1:0] MODE_RSVD = 2'd3;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CLR   = 3'd1;
   localparam logic [2:0] ST_RUN   = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam int          DRAIN_DEF   = 8;
   localparam logic [15:0] TIMEOUT_DEF = 16'd4000;

   // Core configuration for a given phase of a job.
   function automatic logic [2:0] phase_conf(
      input logic [1:0] mode,
      input logic [1:0] phase
   );
      case (mode)
         MODE_NTT:  return CONF_NTT_A;
         MODE_INTT: return CONF_INTT;
         MODE_MUL:  return {1'b0, phase} + 3'd1;
         default:   return CONF_HOLD;
      endcase
   endfunction

   // Index of the final phase of a job.
   function automatic logic [1:0] last_phase(input logic [1:0] mode);
      return (mode == MODE_MUL) ? 2'd3 : 2'd0;
   endfunction

endpackage

// File: rtl/poly_mul_sequencer_phase_timer.sv
// RUN watchdog timer (16-bit up count) and DRAIN down-counter.
// Ports: clk, rst; clear/enable drive the RUN timer, load arms the DRAIN
// count; expire flags timer==TIMEOUT-1, drained flags the last DRAIN cycle.
module phase_timer
   import poly_mul_pkg::*;
#(
   parameter int          DRAIN   = DRAIN_DEF,
   parameter logic [15:0] TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   input  logic load,
   output logic expire,
   output logic drained
);

   logic [15:0] timer;
   logic [15:0] dcnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         timer <= '0;
         dcnt  <= '0;
      end else begin
         if (clear) begin
            timer <= '0;
         end else if (enable) begin
            timer <= timer + 16'd1;
         end
         // Loaded with DRAIN-1 so the count hits zero on the last cycle.
         if (load) begin
            dcnt <= 16'(DRAIN - 1);
         end else if (dcnt != '0) begin
            dcnt <= dcnt - 16'd1;
         end
      end
   end

   assign expire  = (timer == TIMEOUT - 16'd1);
   assign drained = (dcnt == '0);

endmodule

// File: rtl/poly_mul_sequencer.sv
// Sequences NTT / INTT / full-multiply jobs over the core's phases.
// Ports: clk, rst, start, mode[1:0], done_flag[3:0] in; conf[2:0],
// core_clr, busy, done, err, phase[1:0] out (all registered).
module poly_mul_sequencer
   import poly_mul_pkg::*;
#(
   parameter int          DRAIN   = DRAIN_DEF,
   parameter logic [15:0] TIMEOUT = TIMEOUT_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] mode,
   input  logic [3:0] done_flag,
   output logic [2:0] conf,
   output logic       core_clr,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [1:0] phase
);

   logic [2:0] state;
   logic [2:0] state_n;
   logic [1:0] mode_q;
   logic [1:0] mode_n;
   logic [1:0] phase_n;
   logic       err_n;
   logic       expire;
   logic       drained;
   logic       unused_flags;

   assign unused_flags = ^done_flag[3:1];

   phase_timer #(
      .DRAIN   (DRAIN),
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (state == ST_CLR),
      .enable  (state == ST_RUN),
      .load    ((state == ST_RUN) && done_flag[0]),
      .expire  (expire),
      .drained (drained)
   );

   always_comb begin
      state_n = state;
      mode_n  = mode_q;
      phase_n = phase;
      err_n   = err;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (mode == MODE_RSVD) begin
                  err_n = 1'b1;
               end else begin
                  state_n = ST_CLR;
                  mode_n  = mode;
                  phase_n = '0;
                  err_n   = 1'b0;
               end
            end
         end
         ST_CLR: state_n = ST_RUN;
         ST_RUN: begin
            // Completion is checked first so it beats a same-cycle timeout.
            if (done_flag[0]) begin
               state_n = ST_DRAIN;
            end else if (expire) begin
               state_n = ST_IDLE;
               err_n   = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (drained) begin
               if (phase == last_phase(mode_q)) begin
                  state_n = ST_DONE;
               end else begin
                  state_n = ST_CLR;
                  phase_n = phase + 2'd1;
               end
            end
         end
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         mode_q   <= MODE_NTT;
         conf     <= CONF_HOLD;
         core_clr <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         phase    <= '0;
      end else begin
         state    <= state_n;
         mode_q   <= mode_n;
         err      <= err_n;
         phase    <= phase_n;
         core_clr <= (state_n == ST_CLR);
         busy     <= (state_n == ST_CLR) || (state_n == ST_RUN) ||
                     (state_n == ST_DRAIN);
         done     <= (state_n == ST_DONE);
         conf     <= ((state_n == ST_CLR) || (state_n == ST_RUN)) ?
                     phase_conf(mode_n, phase_n) : CONF_HOLD;
      end
   end

endmodule

// File: tb/tb_poly_mul_sequencer.sv
// Self-checking bench for poly_mul_sequencer: cycle model plus directed
// scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_poly_mul_sequencer;

   localparam int DR = 8;
   localparam int TO = 120;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [1:0] mode = 2'd0;
   logic [3:0] done_flag = 4'd0;
   logic [2:0] conf;
   logic       core_clr;
   logic       busy;
   logic       done;
   logic       err;
   logic [1:0] phase;

   int checks = 0;
   int failures = 0;

   poly_mul_sequencer #(
      .DRAIN   (DR),
      .TIMEOUT (16'(TO))
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mode      (mode),
      .done_flag (done_flag),
      .conf      (conf),
      .core_clr  (core_clr),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .phase     (phase)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Behavioural model: job segment (0 idle,1 clear,2 run,3 drain,4 done)
   // with a cycle count inside the segment.
   int tbl [3][4] = '{'{1, 0, 0, 0}, '{4, 0, 0, 0}, '{1, 2, 3, 4}};
   int nph [3] = '{1, 1, 4};
   int m_seg = 0;
   int m_cnt = 0;
   int m_mode = 0;
   int m_ph = 0;
   bit m_err = 1'b0;
   bit m_valid = 1'b0;

   function automatic logic [31:0] m_out();
      logic [2:0] c;
      c = (m_seg == 1 || m_seg == 2) ? 3'(tbl[m_mode][m_ph]) : 3'd0;
      return 32'({c, (m_seg == 1), (m_seg inside {[1:3]}), (m_seg == 4),
                  m_err, 2'(m_ph)});
   endfunction

   task automatic m_step();
      if (rst) begin
         m_seg = 0; m_err = 1'b0; m_ph = 0; m_mode = 0; m_cnt = 0;
         m_valid = 1'b1;
      end else begin
         case (m_seg)
            0: if (start) begin
               if (mode == 2'd3) m_err = 1'b1;
               else begin
                  m_mode = int'(mode); m_err = 1'b0; m_ph = 0; m_seg = 1;
               end
            end
            1: begin m_seg = 2; m_cnt = 0; end
            2: if (done_flag[0]) begin m_seg = 3; m_cnt = 0; end
               else if (m_cnt == TO - 1) begin m_seg = 0; m_err = 1'b1; end
               else m_cnt++;
            3: if (m_cnt == DR - 1) begin
                  if (m_ph + 1 < nph[m_mode]) begin m_ph++; m_seg = 1; end
                  else m_seg = 4;
               end else m_cnt++;
            default: m_seg = 0;
         endcase
      end
   endtask

   always @(negedge clk) begin
      if (m_valid)
         chk("outputs", 32'({conf, core_clr, busy, done, err, phase}),
             m_out());
      m_step();
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int  bcnt, ccnt, dcnt, dcyc, ecyc, rc, rcnt, dfp;
   logic [15:0] seqc, seqp;
   bit  seen, inrun, bad;

   initial begin
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("reset_state", 32'({conf, core_clr, busy, done, err, phase}), 0);

      // mode0, done_flag 100 cycles into RUN
      bcnt = 0; ccnt = 0; dcnt = 0; dcyc = -1;
      for (int c = 0; c < 130; c++) begin
         tick();
         start = (c == 0); mode = 2'd0; done_flag = {3'b0, c == 102};
         if (busy) bcnt++;
         if (conf == 3'd1) ccnt++;
         if (done) begin dcnt++; dcyc = c; end
      end
      chk("m0_done_cycle", dcyc, 111);
      chk("m0_busy_cycles", bcnt, 110);
      chk("m0_conf1_cycles", ccnt, 102);
      chk("m0_done_count", dcnt, 1);

      // mode2, each phase done after 50 RUN cycles
      bcnt = 0; ccnt = 0; dcnt = 0; rc = 0; seqc = 0; seqp = 0;
      for (int c = 0; c < 260; c++) begin
         tick();
         start = (c == 0); mode = 2'd2;
         inrun = (conf != 3'd0) && !core_clr;
         rc = inrun ? rc + 1 : 0;
         done_flag = {3'b0, inrun && rc == 50};
         if (busy) bcnt++;
         if (done) dcnt++;
         if (core_clr) begin
            ccnt++;
            seqc = {seqc[11:0], 1'b0, conf};
            seqp = {seqp[11:0], 2'b0, phase};
         end
      end
      chk("m2_busy_cycles", bcnt, 236);
      chk("m2_clr_count", ccnt, 4);
      chk("m2_conf_seq", seqc, 16'h1234);
      chk("m2_phase_seq", seqp, 16'h0123);
      chk("m2_done_count", dcnt, 1);

      // mode1 timeout
      dcnt = 0; ecyc = -1; rcnt = 0;
      for (int c = 0; c < TO + 20; c++) begin
         tick();
         start = (c == 0); mode = 2'd1; done_flag = 4'd0;
         if (done) dcnt++;
         if (conf == 3'd4 && !core_clr) rcnt++;
         if (err && ecyc < 0) ecyc = c;
      end
      chk("to_err_cycle", ecyc, TO + 2);
      chk("to_run_cycles", rcnt, TO);
      chk("to_done_count", dcnt, 0);
      chk("to_end_state", 32'({conf, busy, err}), 32'b000_0_1);

      // reserved mode then a valid start
      tick(); start = 1'b1; mode = 2'd3;
      tick(); start = 1'b1; mode = 2'd0;
      chk("rsvd_err_busy", 32'({err, busy}), 32'b10);
      tick(); start = 1'b0;
      chk("rsvd_cleared", 32'({err, busy}), 32'b01);
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         tick();
         done_flag = {3'b0, (conf != 3'd0) && !core_clr};
         if (done) seen = 1'b1;
      end
      chk("rsvd_job_done", seen, 1);

      // reset during phase 2 of mode2
      rc = 0; seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
         tick();
         start = (c == 0); mode = 2'd2;
         inrun = (conf != 3'd0) && !core_clr;
         rc = inrun ? rc + 1 : 0;
         done_flag = {3'b0, inrun && rc == 5};
         if (inrun && phase == 2'd2 && rc == 2) begin
            rst = 1'b1; seen = 1'b1;
         end
      end
      chk("rst_reached_ph2", seen, 1);
      tick();
      rst = 1'b0; start = 1'b0; done_flag = 4'd0;
      chk("rst_outputs", 32'({conf, core_clr, busy, done, err, phase}), 0);
      rc = 0; dcyc = -1;
      for (int c = 0; c < 40; c++) begin
         tick();
         start = (c == 0); mode = 2'd0;
         inrun = (conf != 3'd0) && !core_clr;
         rc = inrun ? rc + 1 : 0;
         done_flag = {3'b0, inrun && rc == 3};
         if (done) dcyc = c;
      end
      chk("post_rst_done_cycle", dcyc, 13);

      // extra start in RUN, completion on the timeout cycle
      rc = 0; dcnt = 0; dcyc = -1; bad = 1'b0;
      for (int c = 0; c < TO + 30; c++) begin
         tick();
         inrun = (conf != 3'd0) && !core_clr;
         rc = inrun ? rc + 1 : 0;
         start = (c == 0) || (inrun && rc == 10);
         mode = (c == 0) ? 2'd0 : 2'd2;
         done_flag = {3'b0, inrun && rc == TO};
         if (err || conf == 3'd2) bad = 1'b1;
         if (done) begin dcnt++; dcyc = c; end
      end
      chk("race_no_err", bad, 0);
      chk("race_done_count", dcnt, 1);
      chk("race_done_cycle", dcyc, TO + 10);

      // randomized traffic
      dfp = 5;
      for (int c = 0; c < 4000; c++) begin
         tick();
         if (c % 500 == 0) dfp = (c / 500) % 3 == 0 ? 1 : ((c / 500) % 3 == 1 ? 5 : 30);
         rst = ($urandom_range(0, 599) == 0);
         start = ($urandom_range(0, 7) == 0);
         mode = 2'($urandom_range(0, 3));
         done_flag = {3'($urandom), $urandom_range(0, 99) < dfp};
      end
      tick();
      rst = 1'b0; start = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
